sine_pwm_gen: RTL and testbench
===============================

# sine_pwm_gen

Multi-channel sine-modulated PWM generator: a shared phase accumulator drives CHANNELS outputs, each with its own programmable phase offset. Each channel's duty follows a quarter-wave sine table with programmable amplitude. Duties are recomputed once per PWM period by a time-multiplexed sequencer and applied glitch-free at the next period boundary. It sits between the board clock and the motor/LED drive pins, and replaces fixed-rate, single-channel sine PWM.

## Interface
Parameters:
- CHANNELS, 3, number of PWM outputs (1..8)
- PWM_W, 8, duty/counter width; edge-aligned period = 2^PWM_W-1 clocks
- PHASE_W, 16, phase accumulator width
- LUT_AW, 6, quarter-wave table address width (2^LUT_AW entries)
- DIV_W, 32, prescaler width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run when high; when low: counter and phase frozen, outputs low
- step  in  PHASE_W  phase increment per update tick
- div  in  DIV_W  update tick every div+1 PWM periods
- amp  in  PWM_W  amplitude, scale factor (amp+1)/2^PWM_W
- ch_offset  in  CHANNELS*PHASE_W  per-channel phase offset; channel i uses slice [i*PHASE_W +: PHASE_W]
- pwm_out  out  CHANNELS  PWM outputs, registered
- period_start  out  1  one-cycle pulse at each period boundary (cnt==0)

## Operation
- Reset values:
  - cnt=0, acc=0, prescaler=0, pwm_out=0, period_start=0.
  - Active and shadow duties = 2^(PWM_W-1) (midscale). Sequencer IDLE.
- PWM counter: cnt runs 0..2^PWM_W-2, then wraps to 0. pwm_out[i] = (cnt < duty[i]), registered.
  - duty 0: output always low.
  - duty 2^PWM_W-1: output always high.
- Period boundary (cnt==0, enable high):
  - Active duty ← shadow for all channels.
  - period_start pulses.
  - Sequencer launches using acc_snap = acc.
  - If prescaler==div: acc ← acc+step (mod 2^PHASE_W) and prescaler ← 0. Otherwise prescaler increments.
- Sequencer FSM states: IDLE → CALC (one channel per cycle, i=0..CHANNELS-1) → IDLE.
  - Per channel: p = acc_snap + ch_offset[i] (mod 2^PHASE_W).
  - q = p[PHASE_W-1:PHASE_W-2]; idx = p[PHASE_W-3 -: LUT_AW].
  - For odd q, idx is mirrored: idx' = 2^LUT_AW-1-idx.
  - LUT entry: L = round((2^(PWM_W-1)-1)·sin(π/2·k/2^LUT_AW)). For PWM_W=8: L[0]=0, L[63]=127.
  - Scaling: s = (L·(amp+1)) >> PWM_W. The product is PWM_W+PWM_W bits wide; no overflow.
  - Duty: q<2 gives 2^(PWM_W-1)+s; q≥2 gives 2^(PWM_W-1)-s.
  - The result is written to shadow[i].
- Stable inputs: step, div, amp and ch_offset are sampled at the boundary / during CALC. Changes take effect in the next period's computation. A div change takes effect at the next prescaler compare.
- enable falling: the next clock forces cnt=0, pwm_out=0 and the sequencer to IDLE. acc, prescaler and shadow are held.
- enable rising: the first clock is a period boundary (cnt==0).
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Timing
- Sequencer latency: CHANNELS+2 cycles (1 launch, CHANNELS CALC, 1 write).
- Constraint: period must be > CHANNELS+2 clocks. An elaboration-time check errors out otherwise.
- Duty latency: the duty in period k is computed from acc at boundary k-1. Period 0 after reset uses midscale.
- pwm_out follows the cnt compare with 1-cycle register latency.
- Simultaneous events:
  - Boundary during CALC is impossible by the constraint above.
  - Prescaler wrap and boundary coincide by design.

## Configuration
- SINE_PWM_CENTER_EN defined:
  - cnt counts up 0..2^PWM_W-1, then down to 1. Period = 2·(2^PWM_W-1) clocks.
  - Output is high while cnt < duty, giving a symmetric pulse.
  - The boundary is cnt==0 on the up-count.
- Not defined: edge-aligned as described above.

## Structure
- Package sine_pwm_pkg holds:
  - the sequencer state enum (IDLE, CALC);
  - the quadrant typedef;
  - the LUT generation function;
  - the MIDSCALE constant function of PWM_W.
- One sub-module, sine_quarter_lut: combinational/ROM lookup with parameters LUT_AW and PWM_W. It is shared by all channels through the sequencer.

## Test plan
All cases use PWM_W=8 unless stated.
1. Reset and first period: release reset, enable=1, step=0, amp=255, offsets 0 → period 0 duty 128, i.e. pwm_out high 128 clocks of 255. period_start every 255 clocks.
2. Quarter stepping: step=16384, div=0, amp=255, ch0 offset 0 → duties over successive periods 128,128,255,128,1,128,255.
3. Offsets: CHANNELS=3, offsets 0/16384/32768, step=0 → after the second boundary, duties are 128/255/128.
4. Amplitude and extremes:
   - amp=127 at peak phase → duty 128+63=191.
   - amp=255 at the q3 peak → duty 1, i.e. one high clock per period.
   - duty 255 → output never low.
5. Prescaler: div=3, step=16384 → acc advances every 4th boundary; each duty value holds for 4 periods.
6. Control: drop enable mid-period → pwm_out=0 next clock and acc held. Re-enable → period_start on the first clock. Assert rst_n low mid-CALC → all outputs 0 asynchronously. Repeat case 2 with SINE_PWM_CENTER_EN → period 510 clocks with a centered pulse.

Source files
------------

// File: rtl/sine_pwm_pkg.sv
// Shared types and elaboration-time helpers for the sine PWM generator:
// sequencer state enum, quadrant type, quarter-wave table generator and the
// midscale duty constant. Contains no logic of its own.
package sine_pwm_pkg;

  typedef enum logic {IDLE, CALC} seq_state_e;

  // Top two phase bits: bit 0 selects a mirrored table walk, bit 1 the negative half-wave.
  typedef logic [1:0] quad_t;

  // Duty value for a 50% output, i.e. the sine zero crossing.
  function automatic int midscale(input int pw);
    return 1 << (pw - 1);
  endfunction

  // Entry k of the quarter-wave table: round((2^(pw-1)-1) * sin(pi/2 * k / 2^aw)).
  function automatic int lut_val(input int k, input int aw, input int pw);
    real peak;
    real ang;
    peak = real'((1 << (pw - 1)) - 1);
    ang  = 3.14159265358979 / 2.0 * real'(k) / real'(1 << aw);
    return $rtoi(peak * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine ROM, combinational read, shared by all channels.
// Ports: addr (LUT_AW) table index; data (PWM_W-1) unsigned sine magnitude.
// Contents are fixed at elaboration from sine_pwm_pkg::lut_val.
module sine_quarter_lut
  import sine_pwm_pkg::*;
#(
  parameter int LUT_AW = 6,
  parameter int PWM_W  = 8
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [PWM_W-2:0]  data
);

  logic [PWM_W-2:0] rom [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    assign rom[k] = (PWM_W-1)'(lut_val(k, LUT_AW, PWM_W));
  end

  assign data = rom[addr];

endmodule

// File: rtl/sine_pwm_gen.sv
// Multi-channel sine-modulated PWM: shared phase accumulator, per-channel phase
// offsets, duties recomputed once per period and swapped in at the period boundary.
// Ports: clk, rst_n (async low), enable, step/div/amp/ch_offset controls;
// pwm_out[CHANNELS] registered outputs, period_start one-cycle boundary pulse.
// Build option: define SINE_PWM_CENTER_EN for a center-aligned (up/down) counter.
module sine_pwm_gen
  import sine_pwm_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int PWM_W    = 8,
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = 6,
  parameter int DIV_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [PHASE_W-1:0]          step,
  input  logic [DIV_W-1:0]            div,
  input  logic [PWM_W-1:0]            amp,
  input  logic [CHANNELS*PHASE_W-1:0] ch_offset,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic                        period_start
);

`ifdef SINE_PWM_CENTER_EN
  localparam int PERIOD = 2 * (2**PWM_W - 1);
`else
  localparam int PERIOD = 2**PWM_W - 1;
  localparam logic [PWM_W-1:0] CNT_TOP = PWM_W'(2**PWM_W - 2);
`endif
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [PWM_W-1:0] MID     = PWM_W'(midscale(PWM_W));

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("sine_pwm_gen: CHANNELS must be in 1..8");
  end
  // The sequencer must finish its write before the next boundary swaps shadow into active.
  if (PERIOD <= CHANNELS + 2) begin : g_bad_period
    $error("sine_pwm_gen: PWM period too short for the duty sequencer");
  end
  if (LUT_AW > PHASE_W - 3) begin : g_bad_lut
    $error("sine_pwm_gen: LUT_AW must leave at least one fractional phase bit");
  end

  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [PHASE_W-1:0] acc_snap_q, acc_snap_d;
  seq_state_e         state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               wr_vld_q, wr_vld_d;
  logic [CH_W-1:0]    wr_ch_q, wr_ch_d;
  logic [PWM_W-1:0]   wr_duty_q, wr_duty_d;
  logic [PWM_W-1:0]   active_q [CHANNELS];
  logic [PWM_W-1:0]   active_d [CHANNELS];
  logic [PWM_W-1:0]   shadow_q [CHANNELS];
  logic [PWM_W-1:0]   shadow_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic               period_start_q, period_start_d;
`ifdef SINE_PWM_CENTER_EN
  logic               dir_down_q, dir_down_d;
`endif

  logic boundary;
  assign boundary = enable && (cnt_q == '0);

  // Duty datapath for the channel currently selected by the sequencer.
  logic [PHASE_W-1:0] offs [CHANNELS];
  for (genvar g = 0; g < CHANNELS; g++) begin : g_offs
    assign offs[g] = ch_offset[g*PHASE_W +: PHASE_W];
  end

  logic [PHASE_W-1:0]   phase;
  quad_t                quad;
  logic [LUT_AW-1:0]    idx;
  logic [LUT_AW-1:0]    lut_addr;
  logic [PWM_W-2:0]     lut_data;
  logic [2*PWM_W-1:0]   prod;
  logic [PWM_W-1:0]     scaled;
  logic [PWM_W-1:0]     calc_duty;

  assign phase    = acc_snap_q + offs[ch_q];
  assign quad     = phase[PHASE_W-1 -: 2];
  assign idx      = phase[PHASE_W-3 -: LUT_AW];
  // Quadrants 1 and 3 walk the quarter table backwards.
  assign lut_addr = quad[0] ? ~idx : idx;

  sine_quarter_lut #(
    .LUT_AW (LUT_AW),
    .PWM_W  (PWM_W)
  ) u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // L * (amp+1) >> PWM_W; peak L is 2^(PWM_W-1)-1, so MID +/- scaled stays in range.
  assign prod      = (2*PWM_W)'(lut_data) * ((2*PWM_W)'(amp) + (2*PWM_W)'(1));
  assign scaled    = prod[2*PWM_W-1 -: PWM_W];
  assign calc_duty = quad[1] ? (MID - scaled) : (MID + scaled);

  // Fractional phase bits and the product remainder are deliberately discarded.
  logic unused_bits;
  assign unused_bits = ^{phase[PHASE_W-3-LUT_AW:0], prod[PWM_W-1:0]};

  always_comb begin
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    pre_d          = pre_q;
    acc_snap_d     = acc_snap_q;
    state_d        = state_q;
    ch_d           = ch_q;
    wr_vld_d       = 1'b0;
    wr_ch_d        = wr_ch_q;
    wr_duty_d      = wr_duty_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    pwm_d          = '0;
    period_start_d = 1'b0;
`ifdef SINE_PWM_CENTER_EN
    dir_down_d     = dir_down_q;
`endif

    if (!enable) begin
      // Park at cnt 0 so the first enabled clock is a boundary; acc/prescaler/shadow hold.
      cnt_d   = '0;
      state_d = IDLE;
`ifdef SINE_PWM_CENTER_EN
      dir_down_d = 1'b0;
`endif
    end else begin
`ifdef SINE_PWM_CENTER_EN
      if (dir_down_q) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == PWM_W'(1)) dir_down_d = 1'b0;
      end else if (&cnt_q) begin
        cnt_d      = cnt_q - 1'b1;
        dir_down_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`else
      cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
`endif

      period_start_d = boundary;
      // The compare at the boundary already uses the incoming duty, so a period never mixes two duties.
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = cnt_q < (boundary ? shadow_q[i] : active_q[i]);
      end

      if (boundary) begin
        active_d   = shadow_q;
        acc_snap_d = acc_q;
        state_d    = CALC;
        ch_d       = '0;
        if (pre_q == div) begin
          acc_d = acc_q + step;
          pre_d = '0;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end

      if (state_q == CALC) begin
        wr_vld_d  = 1'b1;
        wr_ch_d   = ch_q;
        wr_duty_d = calc_duty;
        if (ch_q == LAST_CH) state_d = IDLE;
        else                 ch_d    = ch_q + 1'b1;
      end

      if (wr_vld_q) shadow_d[wr_ch_q] = wr_duty_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      acc_q          <= '0;
      pre_q          <= '0;
      acc_snap_q     <= '0;
      state_q        <= IDLE;
      ch_q           <= '0;
      wr_vld_q       <= 1'b0;
      wr_ch_q        <= '0;
      wr_duty_q      <= MID;
      active_q       <= '{default: MID};
      shadow_q       <= '{default: MID};
      pwm_q          <= '0;
      period_start_q <= 1'b0;
`ifdef SINE_PWM_CENTER_EN
      dir_down_q     <= 1'b0;
`endif
    end else begin
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      pre_q          <= pre_d;
      acc_snap_q     <= acc_snap_d;
      state_q        <= state_d;
      ch_q           <= ch_d;
      wr_vld_q       <= wr_vld_d;
      wr_ch_q        <= wr_ch_d;
      wr_duty_q      <= wr_duty_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
`ifdef SINE_PWM_CENTER_EN
      dir_down_q     <= dir_down_d;
`endif
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_sine_pwm_gen.sv
// Self-checking bench for sine_pwm_gen (CHANNELS=3, PWM_W=8): measures high time
// per channel over each PWM period and compares against a per-period duty model
// derived from the sine formula, plus literal values for the directed scenarios.
module tb_sine_pwm_gen;

  localparam int CH = 3;
`ifdef SINE_PWM_CENTER_EN
  localparam int PERIOD = 510;
`else
  localparam int PERIOD = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] step = '0;
  logic [31:0] div = '0;
  logic [7:0]  amp = '0;
  logic [47:0] ch_offset = '0;
  logic [2:0]  pwm_out;
  logic        period_start;

  always #5 clk = ~clk;

  sine_pwm_gen #(
    .CHANNELS (3),
    .PWM_W    (8),
    .PHASE_W  (16),
    .LUT_AW   (6),
    .DIV_W    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .step         (step),
    .div          (div),
    .amp          (amp),
    .ch_offset    (ch_offset),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned m_acc, m_pre;
  int          m_cur [CH];
  int          m_next [CH];
  int unsigned off [CH];
  int          hc [CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Ideal duty from phase: sine magnitude per quadrant, rounded table, scaled by (amp+1)/256.
  function automatic int ref_duty(input int unsigned ph, input int a);
    int q, idx, lv, s;
    q   = int'(ph / 16384);
    idx = int'((ph % 16384) / 256);
    if (q % 2 == 1) idx = 63 - idx;
    lv = $rtoi(127.0 * $sin(3.14159265358979 * real'(idx) / 128.0) + 0.5);
    s  = (lv * (a + 1)) / 256;
    return (q < 2) ? 128 + s : 128 - s;
  endfunction

  // Clocks high per period for a duty value.
  function automatic int exp_high(input int d);
`ifdef SINE_PWM_CENTER_EN
    return (d == 0) ? 0 : 2 * d - 1;
`else
    return d;
`endif
  endfunction

  task automatic set_inputs(input int unsigned st, input int unsigned dv, input int unsigned a,
                            input int unsigned o0, input int unsigned o1, input int unsigned o2);
    step      = 16'(st);
    div       = dv;
    amp       = 8'(a);
    off[0]    = o0 % 65536;
    off[1]    = o1 % 65536;
    off[2]    = o2 % 65536;
    ch_offset = {16'(o2), 16'(o1), 16'(o0)};
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_pre = 0;
    for (int c = 0; c < CH; c++) begin
      m_cur[c]  = 128;
      m_next[c] = 128;
    end
  endtask

  task automatic model_boundary();
    for (int c = 0; c < CH; c++) begin
      m_cur[c]  = m_next[c];
      m_next[c] = ref_duty((m_acc + off[c]) % 65536, int'(amp));
    end
    if (m_pre == div) begin
      m_acc = (m_acc + int'(step)) % 65536;
      m_pre = 0;
    end else begin
      m_pre++;
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (period_start !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(period_start), 1);
  endtask

  // Returns at the negedge of the last cycle of the measured period.
  task automatic measure(input string tag);
    int ps_cnt = 0;
    wait_start(tag);
    model_boundary();
    for (int c = 0; c < CH; c++) hc[c] = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      ps_cnt += int'(period_start);
      for (int c = 0; c < CH; c++) hc[c] += int'(pwm_out[c]);
    end
    check({tag, "_len"}, 32'(ps_cnt), 1);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s_ch%0d", tag, c), 32'(hc[c]), 32'(exp_high(m_cur[c])));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t2 [7];
    t2 = '{128, 128, 255, 128, 1, 128, 255};

    // Reset state and first boundary
    set_inputs(0, 0, 255, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_ps", 32'(period_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_pwm", 32'(pwm_out), 0);
    enable = 1'b1;
    @(negedge clk);
    check("first_ps", 32'(period_start), 1);
    check("first_pwm", 32'(pwm_out), 32'h7);
    measure("t1_p0");
    check("t1_mid", 32'(hc[0]), 32'(exp_high(128)));
    measure("t1_p1");

    // Quarter stepping with three offsets from reset
    do_reset();
    set_inputs(16384, 0, 255, 0, 16384, 32768);
    for (int k = 0; k < 7; k++) begin
      measure($sformatf("t2_p%0d", k));
      check($sformatf("t2_lit%0d", k), 32'(hc[0]), 32'(exp_high(t2[k])));
      if (k == 1) begin
        check("t3_ch1", 32'(hc[1]), 32'(exp_high(255)));
        check("t3_ch2", 32'(hc[2]), 32'(exp_high(128)));
      end
    end

    // Reduced amplitude at both peaks
    do_reset();
    set_inputs(0, 0, 127, 16384, 49152, 0);
    measure("t4_p0");
    measure("t4_p1");
    check("t4_peak", 32'(hc[0]), 32'(exp_high(191)));
    check("t4_trough", 32'(hc[1]), 32'(exp_high(65)));

    // Prescaler: acc advances on every 4th boundary
    do_reset();
    set_inputs(16384, 3, 255, 0, 16384, 32768);
    for (int k = 0; k < 9; k++) begin
      measure($sformatf("t5_p%0d", k));
      if (k >= 1 && k <= 4) check($sformatf("t5_hold%0d", k), 32'(hc[0]), 32'(exp_high(128)));
      if (k >= 5)           check($sformatf("t5_hold%0d", k), 32'(hc[0]), 32'(exp_high(255)));
    end

    // Randomized controls against the model
    for (int r = 0; r < 6; r++) begin
      set_inputs($urandom, $urandom_range(0, 2), $urandom_range(0, 255),
                 $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
      for (int k = 0; k < 3; k++) measure($sformatf("rnd%0d_p%0d", r, k));
    end

    // Enable drop mid-period, then re-enable
    set_inputs(16384, 0, 255, 0, 16384, 32768);
    wait_start("dis");
    model_boundary();
    repeat (100) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_pwm", 32'(pwm_out), 0);
    check("dis_ps", 32'(period_start), 0);
    repeat (40) @(negedge clk);
    check("dis_hold", 32'(pwm_out), 0);
    enable = 1'b1;
    @(negedge clk);
    check("reen_ps", 32'(period_start), 1);
    measure("reen_p0");
    measure("reen_p1");

    // Asynchronous reset while the sequencer is calculating
    set_inputs(0, 0, 255, 0, 0, 0);
    wait_start("ar");
    rst_n = 1'b0;
    #1;
    check("ar_pwm", 32'(pwm_out), 0);
    check("ar_ps", 32'(period_start), 0);
    model_reset();
    @(negedge clk);
    check("ar_hold", 32'(pwm_out), 0);
    rst_n = 1'b1;
    measure("ar_p0");
    measure("ar_p1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
